// File: rtl/ps2_kbmat_if.sv
// Keymap ROM lookup bus between the PS/2 decoder (master) and the external keymap (slave).
interface ps2_kbmat_if;
   logic [7:0] map_code;
   logic       map_ext;
   logic       map_hit;
   logic [5:0] map_idx;

   modport master (
      output map_code,
      output map_ext,
      input  map_hit,
      input  map_idx
   );

   modport slave (
      input  map_code,
      input  map_ext,
      output map_hit,
      output map_idx
   );
endinterface

// File: rtl/ps2_kbmat.sv
// PS/2 device-to-host receiver, scancode decoder and Z88 key-matrix state for the Blink KBD port.
module ps2_kbmat #(
   parameter int unsigned TIMEOUT = 9830,
   parameter int unsigned SYNC    = 2
) (
   input  logic        mck,
   input  logic        rin_n,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   ps2_kbmat_if.master map,
   output logic [63:0] kbmat,
   output logic        kb_evt,
   output logic        frm_err
);

   localparam int unsigned ToW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StData   = 2'd1;
   localparam logic [1:0] StParity = 2'd2;
   localparam logic [1:0] StStop   = 2'd3;

   logic [SYNC-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC-1:0] dat_sync_q, dat_sync_d;
   logic            clk_prev_q, clk_prev_d;
   logic [1:0]      state_q, state_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            par_q, par_d;
   logic [ToW-1:0]  to_cnt_q, to_cnt_d;
   logic            byte_valid_q, byte_valid_d;
   logic            frm_err_q, frm_err_d;
   logic            ext_q, ext_d;
   logic            brk_q, brk_d;
   logic [2:0]      skip_q, skip_d;
   logic            lookup_q, lookup_d;
   logic [7:0]      map_code_q, map_code_d;
   logic            map_ext_q, map_ext_d;
   logic [63:0]     kbmat_q, kbmat_d;
   logic            kb_evt_q, kb_evt_d;

   logic clk_s, dat_s, fall;

   assign clk_s = clk_sync_q[SYNC-1];
   assign dat_s = dat_sync_q[SYNC-1];
   assign fall  = clk_prev_q & ~clk_s;

   always_comb begin
      clk_sync_d   = {clk_sync_q[SYNC-2:0], ps2_clk};
      dat_sync_d   = {dat_sync_q[SYNC-2:0], ps2_dat};
      clk_prev_d   = clk_s;
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      shreg_d      = shreg_q;
      par_d        = par_q;
      to_cnt_d     = '0;
      byte_valid_d = 1'b0;
      frm_err_d    = 1'b0;
      ext_d        = ext_q;
      brk_d        = brk_q;
      skip_d       = skip_q;
      lookup_d     = 1'b0;
      map_code_d   = map_code_q;
      map_ext_d    = map_ext_q;
      kbmat_d      = kbmat_q;
      kb_evt_d     = 1'b0;

      if (state_q != StIdle && !fall) begin
         to_cnt_d = to_cnt_q + ToW'(1);
      end

      if (fall) begin
         case (state_q)
            StIdle: begin
               if (!dat_s) begin
                  state_d  = StData;
                  bitcnt_d = 3'd0;
               end
            end
            StData: begin
               shreg_d  = {dat_s, shreg_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_d = StParity;
               end
            end
            StParity: begin
               par_d   = dat_s;
               state_d = StStop;
            end
            default: begin
               if (dat_s && (^{shreg_q, par_q})) begin
                  byte_valid_d = 1'b1;
               end else begin
                  frm_err_d = 1'b1;
               end
               state_d = StIdle;
            end
         endcase
      end else if (state_q != StIdle && to_cnt_q == ToW'(TIMEOUT)) begin
         state_d   = StIdle;
         frm_err_d = 1'b1;
         to_cnt_d  = '0;
      end

      // shreg_q still holds the received byte here: no edge can arrive one cycle after the stop bit
      if (byte_valid_q) begin
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
         end else begin
            case (shreg_q)
               8'hE0: ext_d = 1'b1;
               8'hF0: brk_d = 1'b1;
               8'hE1: begin
                  skip_d = 3'd7;
                  ext_d  = 1'b0;
                  brk_d  = 1'b0;
               end
               8'hAA: begin
                  kbmat_d = '0;
                  ext_d   = 1'b0;
                  brk_d   = 1'b0;
               end
               8'h00, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
               default: begin
                  lookup_d   = 1'b1;
                  map_code_d = shreg_q;
                  map_ext_d  = ext_q;
               end
            endcase
         end
      end

      if (lookup_q) begin
         if (map.map_hit) begin
            kbmat_d[map.map_idx] = ~brk_q;
            kb_evt_d             = 1'b1;
         end
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
   end

   always_ff @(posedge mck or negedge rin_n) begin
      if (!rin_n) begin
         clk_sync_q   <= '1;
         dat_sync_q   <= '1;
         clk_prev_q   <= 1'b1;
         state_q      <= StIdle;
         bitcnt_q     <= 3'd0;
         shreg_q      <= 8'h00;
         par_q        <= 1'b0;
         to_cnt_q     <= '0;
         byte_valid_q <= 1'b0;
         frm_err_q    <= 1'b0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         skip_q       <= 3'd0;
         lookup_q     <= 1'b0;
         map_code_q   <= 8'h00;
         map_ext_q    <= 1'b0;
         kbmat_q      <= '0;
         kb_evt_q     <= 1'b0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         dat_sync_q   <= dat_sync_d;
         clk_prev_q   <= clk_prev_d;
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         to_cnt_q     <= to_cnt_d;
         byte_valid_q <= byte_valid_d;
         frm_err_q    <= frm_err_d;
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         skip_q       <= skip_d;
         lookup_q     <= lookup_d;
         map_code_q   <= map_code_d;
         map_ext_q    <= map_ext_d;
         kbmat_q      <= kbmat_d;
         kb_evt_q     <= kb_evt_d;
      end
   end

   assign map.map_code = map_code_q;
   assign map.map_ext  = map_ext_q;
   assign kbmat        = kbmat_q;
   assign kb_evt       = kb_evt_q;
   assign frm_err      = frm_err_q;

endmodule

// File: doc/ps2_kbmat.md
Name: ps2_kbmat

Overview:
Keyboard front end that feeds the Blink keyboard input. It receives PS/2 device-to-host frames and decodes make, break and E0-extended scancodes. Each decoded key is mapped through an external keymap ROM to a Z88 matrix position, and the block maintains the 64-bit key-state vector `kbmat` consumed by the Blink KBD port (bit set = key held). `kbmat[8*c+r]` is column c (selected by `ca[8+c]` low) and row r.

Parameters:
TIMEOUT, 9830, mck cycles without a PS/2 falling edge before an in-progress frame is aborted (~1 ms at 9.83 MHz).
SYNC, 2, number of synchroniser flops on `ps2_clk` and `ps2_dat` (minimum 2).

Ports:
mck  input  1  9.83 MHz master clock; the only clock.
rin_n  input  1  reset, asynchronous, active-low.
ps2_clk  input  1  PS/2 clock from the keyboard (asynchronous, open-collector).
ps2_dat  input  1  PS/2 data from the keyboard (asynchronous).
map_code  output  8  scancode presented to the keymap ROM.
map_ext  output  1  1 = code was E0-prefixed.
map_hit  input  1  keymap result: 1 = code maps to a matrix key.
map_idx  input  6  keymap result: matrix bit index 0..63.
kbmat  output  64  key state, 1 = pressed.
kb_evt  output  1  one-cycle pulse when a `kbmat` bit is written.
frm_err  output  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset (`rin_n` low, asynchronous):
  - `kbmat`=0, `map_code`=0, `map_ext`=0, `kb_evt`=0, `frm_err`=0.
  - Receiver goes to IDLE; decoder flags are cleared; skip counter is 0.
  - Synchroniser flops are set to 1.
  - Reset asserted mid-frame discards the partial frame.
- Edge detect: a falling edge is synced `ps2_clk` previous=1, current=0. Cycle E is the first mck cycle in which that condition is seen. Data is sampled from synced `ps2_dat` in cycle E.
- Receiver FSM, advancing on falling edges only:
  - IDLE: start bit. If the sample is 0, go to DATA with bitcnt=0; if 1, stay in IDLE with no error.
  - DATA: shift 8 bits in, LSB first. After bit 7, go to PARITY.
  - PARITY: store the bit. Odd parity is required: XOR of the 8 data bits and the parity bit must equal 1.
  - STOP: the stop bit must be 1. If stop and parity are both good, `byte_valid` (internal) pulses in cycle E+1. Otherwise `frm_err` pulses in cycle E+1. In both cases the FSM returns to IDLE.
  - Timeout: in any state other than IDLE, a counter counts mck cycles since the last falling edge. When it reaches TIMEOUT, the frame is aborted, the FSM goes to IDLE and `frm_err` pulses. The counter clears on every falling edge.
- Decoder, acting on `byte_valid`, with flags `ext` and `brk`:
  - skip>0: decrement skip; the byte is otherwise ignored.
  - 0xE0: set `ext`.
  - 0xF0: set `brk`.
  - 0xE1: skip=7 (Pause sequence discarded); clear flags.
  - 0xAA (self-test pass / reconnect): `kbmat` becomes 0; clear flags.
  - 0x00, 0xEE, 0xFA, 0xFC, 0xFD, 0xFE, 0xFF: ignored; clear flags.
  - Any other byte: in cycle E+2, `map_code`=byte and `map_ext`=`ext`.
- Keymap lookup timing:
  - The keymap ROM is combinational. `map_hit` and `map_idx` are sampled at the end of cycle E+2.
  - If `map_hit`=1: `kbmat[map_idx]` <= !`brk` and `kb_evt`=1, both visible in cycle E+3.
  - If `map_hit`=0: no change.
  - Flags clear in either case.
  - `map_code` and `map_ext` hold their value until the next lookup.
- Write semantics:
  - A repeat make of a held key rewrites 1; `kb_evt` still pulses.
  - A break for a key that is not held writes 0; `kb_evt` still pulses.
  - Multiple keys may be held simultaneously; no ghosting logic.
- Frame errors and timeouts never modify `kbmat` or the flags; only the partial byte is lost.
- Minimum PS/2 bit period is ~60 us, so a new `byte_valid` cannot arrive before the previous lookup completes. No queueing is needed.

Test Plan:
1. Frame 0x1C (start 0, data LSB first, parity 0, stop 1), keymap returns hit, idx=12 -> `map_code`=0x1C and `map_ext`=0 at E+2; `kbmat`=0x0000_0000_0000_1000 and a single `kb_evt` at E+3.
2. Frames F0, 1C after scenario 1 -> `kbmat`[12]=0, `kb_evt` pulses once, no event on the F0 byte.
3. Frames E0, 75 with the keymap mapping (0x75, ext=1) to idx=63 -> `map_ext`=1 and `kbmat`[63]=1; then E0, F0, 75 -> `kbmat`[63]=0.
4. Frame 0x1C with parity bit 1 -> `frm_err` pulses in E+1 and `kbmat` is unchanged. A following valid F0, 1C frame pair still decodes correctly (flags not corrupted).
5. Start bit plus 4 data bits, then `ps2_clk` held high for TIMEOUT+10 cycles -> exactly one `frm_err` pulse. The next full frame 0x1C is received correctly.
6. Keys idx 0 and 40 held; `rin_n` pulsed low mid-frame -> all outputs 0 immediately. A separate run holding the same keys and then receiving frame 0xAA -> `kbmat`=0 and no `kb_evt`.
